// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_pkg
//  Description : Shared defaults for the writeback arbiter: data/register
//                widths, requester count and the fixed requester indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

   localparam int NUM_REQ_DEFAULT    = 3;
   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int REG_WIDTH_DEFAULT  = 5;

   // Requester slot assignment on the shared write port.
   typedef enum int {
      REQ_ALU = 0,
      REQ_LSU = 1,
      REQ_MDU = 2
   } req_id_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback bus between the requesters / issue stage (master)
//                and the arbiter (slave).
//                  req_valid/req_ready/req_reg/req_data : writeback handshake
//                  reserve_en/reserve_reg               : scoreboard reserve
//                  reg_write/wr_reg/wr_data             : register file port
//                  busy_mask                            : scoreboard state
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEFAULT,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int REG_WIDTH  = REG_WIDTH_DEFAULT
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*REG_WIDTH-1:0]  req_reg;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic                          reserve_en;
   logic [REG_WIDTH-1:0]          reserve_reg;
   logic                          reg_write;
   logic [REG_WIDTH-1:0]          wr_reg;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic [(1<<REG_WIDTH)-1:0]     busy_mask;

   modport master (
      output req_valid, req_reg, req_data, reserve_en, reserve_reg,
      input  req_ready, reg_write, wr_reg, wr_data, busy_mask
   );

   modport slave (
      input  req_valid, req_reg, req_data, reserve_en, reserve_reg,
      output req_ready, reg_write, wr_reg, wr_data, busy_mask
   );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Searches req starting at
//                ptr, wrapping modulo N; first set bit wins.
//                  req   : request vector
//                  ptr   : search start index (0..N-1), held by the parent
//                  grant : one-hot grant, zero when nothing requests
//                  idx   : encoded index of the granted request
//                  any   : at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int               j;
   logic [IDX_W-1:0] j_idx;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      j_idx = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         j_idx = IDX_W'(j);
         if (!any && req[j_idx]) begin
            any          = 1'b1;
            grant[j_idx] = 1'b1;
            idx          = j_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin arbiter sharing the register file write port
//                between NUM_REQ writeback requesters, with a registered
//                write command and a per-register busy scoreboard.
//                  clk   : clock, all state on rising edge
//                  reset : asynchronous active-high reset
//                  bus   : writeback/scoreboard interface (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEFAULT,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int REG_WIDTH  = REG_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   regfile_wb_arbiter_if.slave bus
);

   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int NUM_REGS = 1 << REG_WIDTH;

   logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_WIDTH-1:0]  wr_reg_q,    wr_reg_d;
   logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
   logic [NUM_REGS-1:0]   busy_q,      busy_d;

   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_any;
   logic                  xfer;
   logic [REG_WIDTH-1:0]  sel_reg;
   logic [DATA_WIDTH-1:0] sel_data;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // Ready is masked during reset so nothing can be handed over while the
   // state is being cleared.
   assign bus.req_ready = reset ? '0 : grant;
   assign xfer          = grant_any & ~reset;
   assign sel_reg       = bus.req_reg [grant_idx*REG_WIDTH  +: REG_WIDTH];
   assign sel_data      = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      reg_write_d = 1'b0;
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
      busy_d      = busy_q;

      if (xfer) begin
         // Writes to register 0 are consumed but never reach the file.
         reg_write_d = (sel_reg != '0);
         wr_reg_d    = sel_reg;
         wr_data_d   = sel_data;
         rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end

      // Clear before set: a fresh reservation of the register being
      // written back means another producer is now outstanding.
      if (reg_write_q) begin
         busy_d[wr_reg_q] = 1'b0;
      end
      if (bus.reserve_en && (bus.reserve_reg != '0)) begin
         busy_d[bus.reserve_reg] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q    <= IDX_W'(REQ_ALU);
         reg_write_q <= 1'b0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
         busy_q      <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         reg_write_q <= reg_write_d;
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.reg_write = reg_write_q;
   assign bus.wr_reg    = wr_reg_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy_mask = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter: directed vector
//                table, mid-stream reset sequence and randomized traffic
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int NR = 3;
   localparam int DW = 32;
   localparam int RW = 5;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'h3333_0002;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .REG_WIDTH(RW)) bus ();

   regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic ren, input logic [4:0] rreg);
      bus.req_valid   = v;
      bus.req_reg     = {r2, r1, r0};
      bus.req_data    = {d2, d1, d0};
      bus.reserve_en  = ren;
      bus.reserve_reg = rreg;
   endtask

   typedef struct {
      logic [2:0]  valid;
      logic [4:0]  r0, r1, r2;
      logic [31:0] d0, d1, d2;
      logic        ren;
      logic [4:0]  rreg;
      logic [2:0]  exp_ready;
      logic        exp_rw;
      logic        chk_wr;
      logic [4:0]  exp_wr_reg;
      logic [31:0] exp_wr_data;
      logic [4:0]  bidx;
      logic        exp_busy;
   } vec_t;

   function automatic vec_t mk(logic [2:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                               logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                               logic ren, logic [4:0] rreg, logic [2:0] er, logic erw,
                               logic cw, logic [4:0] ewr, logic [31:0] ewd,
                               logic [4:0] bi, logic eb);
      vec_t t;
      t.valid = v; t.r0 = r0; t.r1 = r1; t.r2 = r2;
      t.d0 = d0; t.d1 = d1; t.d2 = d2; t.ren = ren; t.rreg = rreg;
      t.exp_ready = er; t.exp_rw = erw; t.chk_wr = cw;
      t.exp_wr_reg = ewr; t.exp_wr_data = ewd; t.bidx = bi; t.exp_busy = eb;
      return t;
   endfunction

   vec_t tbl[17];

   // Behavioural model state for the randomized phase.
   int          m_ptr;
   logic [31:0] m_busy;
   logic        m_rw;
   logic [4:0]  m_wr_reg;
   logic [31:0] m_wr_data;
   logic        m_known;
   logic        pend[NR];
   logic [4:0]  preg[NR];
   logic [31:0] pdat[NR];

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b1;
      drive(3'b111, 5'd1, 5'd2, 5'd3, D0, D1, D2, 1'b1, 5'd4);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", bus.req_ready, 3'b000);
      chk("reset_reg_write", bus.reg_write, 1'b0);
      chk("reset_wr_reg", bus.wr_reg, 5'd0);
      chk("reset_wr_data", bus.wr_data, 32'd0);
      chk("reset_busy", bus.busy_mask, 32'd0);
      reset = 1'b0;

      // ---------------- directed vector table ----------------
      //           valid   r0 r1 r2 d0            d1            d2            ren rreg ready  rw cw wr  wdata         bidx busy
      tbl[0]  = mk(3'b010, 0, 7, 0, 0,            32'hDEADBEEF, 0,            0, 0,  3'b010, 1, 1, 7, 32'hDEADBEEF, 7, 0);
      tbl[1]  = mk(3'b100, 0, 0, 0, 0,            0,            D2,           0, 0,  3'b100, 0, 0, 0, 0,            0, 0);
      tbl[2]  = mk(3'b111, 1, 2, 3, D0,           D1,           D2,           0, 0,  3'b001, 1, 1, 1, D0,           1, 0);
      tbl[3]  = mk(3'b111, 1, 2, 3, D0,           D1,           D2,           0, 0,  3'b010, 1, 1, 2, D1,           2, 0);
      tbl[4]  = mk(3'b111, 1, 2, 3, D0,           D1,           D2,           0, 0,  3'b100, 1, 1, 3, D2,           3, 0);
      tbl[5]  = mk(3'b111, 1, 2, 3, D0,           D1,           D2,           0, 0,  3'b001, 1, 1, 1, D0,           1, 0);
      tbl[6]  = mk(3'b111, 1, 2, 3, D0,           D1,           D2,           0, 0,  3'b010, 1, 1, 2, D1,           2, 0);
      tbl[7]  = mk(3'b111, 1, 2, 3, D0,           D1,           D2,           0, 0,  3'b100, 1, 1, 3, D2,           3, 0);
      tbl[8]  = mk(3'b000, 0, 0, 0, 0,            0,            0,            1, 5,  3'b000, 0, 1, 3, D2,           5, 1);
      tbl[9]  = mk(3'b001, 5, 0, 0, 32'h55555555, 0,            0,            0, 0,  3'b001, 1, 1, 5, 32'h55555555, 5, 1);
      tbl[10] = mk(3'b000, 0, 0, 0, 0,            0,            0,            0, 0,  3'b000, 0, 1, 5, 32'h55555555, 5, 0);
      tbl[11] = mk(3'b010, 0, 9, 0, 0,            32'h99999999, 0,            1, 9,  3'b010, 1, 1, 9, 32'h99999999, 9, 1);
      tbl[12] = mk(3'b000, 0, 0, 0, 0,            0,            0,            1, 9,  3'b000, 0, 1, 9, 32'h99999999, 9, 1);
      tbl[13] = mk(3'b100, 0, 0, 9, 0,            0,            32'hAAAA0009, 0, 0,  3'b100, 1, 1, 9, 32'hAAAA0009, 9, 1);
      tbl[14] = mk(3'b000, 0, 0, 0, 0,            0,            0,            0, 0,  3'b000, 0, 1, 9, 32'hAAAA0009, 9, 0);
      tbl[15] = mk(3'b011, 0, 4, 0, 32'h0BAD0000, 32'h44440004, 0,            1, 0,  3'b001, 0, 0, 0, 0,            0, 0);
      tbl[16] = mk(3'b011, 0, 4, 0, 32'h0BAD0000, 32'h44440004, 0,            0, 0,  3'b010, 1, 1, 4, 32'h44440004, 0, 0);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].valid, tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].d0, tbl[i].d1,
               tbl[i].d2, tbl[i].ren, tbl[i].rreg);
         #1;
         chk($sformatf("vec%0d_ready", i), bus.req_ready, tbl[i].exp_ready);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_reg_write", i), bus.reg_write, tbl[i].exp_rw);
         if (tbl[i].chk_wr) begin
            chk($sformatf("vec%0d_wr_reg", i), bus.wr_reg, tbl[i].exp_wr_reg);
            chk($sformatf("vec%0d_wr_data", i), bus.wr_data, tbl[i].exp_wr_data);
         end
         chk($sformatf("vec%0d_busy_bit", i), bus.busy_mask[tbl[i].bidx], tbl[i].exp_busy);
         chk($sformatf("vec%0d_busy0", i), bus.busy_mask[0], 1'b0);
      end

      // ---------------- reset mid-stream ----------------
      // Pointer is 2 here: grant 2 then 0 leaves it at 1 before reset.
      drive(3'b111, 5'd1, 5'd2, 5'd3, D0, D1, D2, 1'b1, 5'd6);
      #1;
      chk("mid_first_ready", bus.req_ready, 3'b100);
      @(posedge clk);
      #1;
      drive(3'b111, 5'd1, 5'd2, 5'd3, D0, D1, D2, 1'b0, 5'd0);
      #1;
      chk("mid_second_ready", bus.req_ready, 3'b001);
      @(posedge clk);
      #2;
      chk("mid_pre_reg_write", bus.reg_write, 1'b1);
      chk("mid_pre_busy6", bus.busy_mask[6], 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_reg_write", bus.reg_write, 1'b0);
      chk("mid_busy", bus.busy_mask, 32'd0);
      chk("mid_ready", bus.req_ready, 3'b000);
      @(posedge clk);
      #1;
      chk("mid_hold_reg_write", bus.reg_write, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_after_ready", bus.req_ready, 3'b001);
      @(posedge clk);
      #1;
      chk("mid_after_wr_reg", bus.wr_reg, 5'd1);

      // ---------------- randomized traffic vs model ----------------
      reset = 1'b1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 5'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_ptr = 0; m_busy = '0; m_rw = 1'b0; m_wr_reg = '0; m_wr_data = '0; m_known = 1'b1;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1'b0; preg[i] = '0; pdat[i] = '0;
      end

      for (int cyc = 0; cyc < 400; cyc++) begin
         int          g;
         logic        ren;
         logic [4:0]  rreg;
         logic [2:0]  v;
         logic [2:0]  exp_ready;
         logic [31:0] nb;

         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               preg[i] = 5'($urandom_range(0, 7));
               pdat[i] = $urandom;
            end
         end
         ren  = ($urandom_range(0, 2) == 0);
         rreg = 5'($urandom_range(0, 7));
         v    = {pend[2], pend[1], pend[0]};
         drive(v, preg[0], preg[1], preg[2], pdat[0], pdat[1], pdat[2], ren, rreg);
         #1;

         g = -1;
         for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (g < 0 && pend[j]) g = j;
         end
         exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
         chk("rand_ready", bus.req_ready, exp_ready);

         nb = m_busy;
         if (m_rw) nb[m_wr_reg] = 1'b0;
         if (ren && rreg != 0) nb[rreg] = 1'b1;

         @(posedge clk);
         m_busy = nb;
         if (g >= 0) begin
            m_rw = (preg[g] != 0);
            if (m_rw) begin
               m_wr_reg  = preg[g];
               m_wr_data = pdat[g];
               m_known   = 1'b1;
            end else begin
               m_known = 1'b0;
            end
            m_ptr   = (g + 1) % NR;
            pend[g] = 1'b0;
         end else begin
            m_rw = 1'b0;
         end
         #1;
         chk("rand_reg_write", bus.reg_write, m_rw);
         if (m_known) begin
            chk("rand_wr_reg", bus.wr_reg, m_wr_reg);
            chk("rand_wr_data", bus.wr_data, m_wr_data);
         end
         chk("rand_busy", bus.busy_mask, m_busy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
